// File: rtl/arb_pkg.sv
// Shared definitions for the bus_arbitro bus arbiter.
// Contents:
//   arb_state_e   - arbiter FSM states (idle, sending, waiting for handshake release)
//   DefNReq       - default number of requesters
//   DefDataW      - default data bus width
//   DefTimeoutCyc - default acknowledge wait limit (used only with ARB_TIMEOUT_EN)
package arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSend    = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

    localparam int unsigned DefNReq       = 4;
    localparam int unsigned DefDataW      = 4;
    localparam int unsigned DefTimeoutCyc = 15;

endpackage

// File: rtl/arb_rr_pick.sv
// Purely combinational round-robin picker.
// Ports:
//   req    in  N_REQ  request vector, bit i belongs to requester i
//   last   in  IDX_W  index of the previous winner
//   winner out N_REQ  one-hot winner, all-zero when no request is pending
//   valid  out 1      at least one request is pending
// Search starts at (last + 1) mod N_REQ and wraps around.
module arb_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] idx;

    assign valid = |req;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after the previous winner is the final assignment to idx.
    always_comb begin
        cand = '0;
        idx  = '0;
        for (int off = int'(N_REQ); off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % int'(N_REQ));
            if (req[cand]) begin
                idx = cand;
            end
        end
        winner = valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/bus_arbitro.sv
// Round-robin arbiter giving N_REQ requesters access to a single peripheral.
// A transfer is a four-phase handshake: the winner's data is latched and
// presented with per_send; per_ack moves to RELEASE where req_ack is held
// until both per_ack and the winner's req_send are low.
// Ports:
//   arb_clock  in  1             clock, rising edge
//   arb_reset  in  1             synchronous active-low reset
//   req_send   in  N_REQ         per-requester data-valid flags
//   req_dados  in  N_REQ*DATA_W  requester data, slice i is requester i
//   req_ack    out N_REQ         receipt ack to the winning requester
//   per_send   out 1             send flag to the peripheral
//   per_dados  out DATA_W        data to the peripheral (0 while idle)
//   per_ack    in  1             peripheral receipt ack
//   arb_grant  out N_REQ         one-hot bus owner, 0 when idle
//   arb_busy   out 1             arbiter not idle
//   arb_erro   out 1             one-cycle acknowledge timeout pulse
// Optional feature: define ARB_TIMEOUT_EN to abort a transfer that is not
// acknowledged within TIMEOUT_CYC cycles; otherwise arb_erro is tied to 0.
module bus_arbitro
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ       = DefNReq,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                    arb_clock,
    input  logic                    arb_reset,
    input  logic [N_REQ-1:0]        req_send,
    input  logic [N_REQ*DATA_W-1:0] req_dados,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    per_send,
    output logic [DATA_W-1:0]       per_dados,
    input  logic                    per_ack,
    output logic [N_REQ-1:0]        arb_grant,
    output logic                    arb_busy,
    output logic                    arb_erro
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic [N_REQ-1:0]  pick_oh;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_data;
    logic [IdxW-1:0]   grant_idx;
    logic              release_ok;
    logic              timeout;

    arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_pick (
        .req    (req_send),
        .last   (last_q),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    // Data slice of the requester the picker selects this cycle.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_oh[i]) begin
                pick_data = req_dados[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q[i]) begin
                grant_idx = IdxW'(i);
            end
        end
    end

    // Handshake closes only once both sides have dropped their flags.
    assign release_ok = ~per_ack & ~(|(req_send & grant_q));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;
    logic            erro_q;

    // Counter is zero on the first SEND cycle; expiry on the last one.
    assign timeout = (state_q == StSend) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge arb_clock) begin
        if (!arb_reset) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= (state_q == StSend) ? cnt_q + CntW'(1) : '0;
            erro_q <= timeout & ~per_ack;
        end
    end

    assign arb_erro = erro_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign arb_erro           = 1'b0;
`endif

    // State register.
    always_ff @(posedge arb_clock) begin
        if (!arb_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack arriving on the expiry edge still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (per_ack) begin
                    state_d = StRelease;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StRelease: begin
                if (release_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant, data and round-robin pointer updates.
    always_comb begin
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_oh;
                    data_d  = pick_data;
                end
            end
            StSend: begin
                if (!per_ack && timeout) begin
                    grant_d = '0;
                    data_d  = '0;
                    last_d  = grant_idx;
                end
            end
            StRelease: begin
                if (release_ok) begin
                    grant_d = '0;
                    data_d  = '0;
                    last_d  = grant_idx;
                end
            end
            default: begin
                grant_d = '0;
                data_d  = '0;
            end
        endcase
    end

    // Pointer resets to N_REQ-1 so requester 0 is searched first.
    always_ff @(posedge arb_clock) begin
        if (!arb_reset) begin
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= IdxW'(N_REQ - 1);
        end else begin
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        per_send  = (state_q == StSend);
        arb_busy  = (state_q != StIdle);
        req_ack   = (state_q == StRelease) ? grant_q : '0;
        arb_grant = grant_q;
        per_dados = data_q;
    end

endmodule

// File: tb/tb_bus_arbitro.sv
// Directed self-checking bench for bus_arbitro with default parameters.
// Outputs are sampled 1 time unit after each rising edge and compared as one
// packed vector {per_send, arb_busy, arb_erro, req_ack, arb_grant, per_dados}.
module tb_bus_arbitro;

    logic        arb_clock = 1'b0;
    logic        arb_reset;
    logic [3:0]  req_send;
    logic [15:0] req_dados;
    logic [3:0]  req_ack;
    logic        per_send;
    logic [3:0]  per_dados;
    logic        per_ack;
    logic [3:0]  arb_grant;
    logic        arb_busy;
    logic        arb_erro;

    logic [14:0] obs;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs = {per_send, arb_busy, arb_erro, req_ack, arb_grant, per_dados};

    bus_arbitro dut (
        .arb_clock (arb_clock),
        .arb_reset (arb_reset),
        .req_send  (req_send),
        .req_dados (req_dados),
        .req_ack   (req_ack),
        .per_send  (per_send),
        .per_dados (per_dados),
        .per_ack   (per_ack),
        .arb_grant (arb_grant),
        .arb_busy  (arb_busy),
        .arb_erro  (arb_erro)
    );

    always #5 arb_clock = ~arb_clock;

    task automatic tick;
        @(posedge arb_clock);
        #1;
    endtask

    task automatic do_reset;
        arb_reset = 1'b0;
        req_send  = 4'b0000;
        per_ack   = 1'b0;
        tick();
        tick();
        arb_reset = 1'b1;
    endtask

    task automatic test_reset;
        arb_reset = 1'b0;
        req_send  = 4'b0000;
        per_ack   = 1'b0;
        req_dados = 16'h1234;
        tick();
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", obs, 15'h0);
        end
        arb_reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_single;
        logic [14:0] exp_v;
        req_dados = 16'h765A;
        req_send  = 4'b0001;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'hA};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_send: got %h want %h", obs, exp_v);
        end
        tick();
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_hold: got %h want %h", obs, exp_v);
        end
        per_ack = 1'b1;
        tick();
        exp_v = {1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'hA};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_ack: got %h want %h", obs, exp_v);
        end
        per_ack = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_release_wait: got %h want %h", obs, exp_v);
        end
        req_send = 4'b0000;
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL single_idle: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_idle_ack;
        per_ack  = 1'b1;
        req_send = 4'b0000;
        tick();
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL idle_ack: got %h want %h", obs, 15'h0);
        end
        per_ack = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_g;
        logic [3:0]  exp_d;
        logic [14:0] exp_v;
        do_reset();
        req_dados = 16'h4321;
        req_send  = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            exp_g = 4'b0001 << (t % 4);
            exp_d = 4'((t % 4) + 1);
            tick();
            exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, exp_g, exp_d};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %h want %h", t, obs, exp_v);
            end
            per_ack = 1'b1;
            tick();
            exp_v = {1'b0, 1'b1, 1'b0, exp_g, exp_g, exp_d};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rr_ack[%0d]: got %h want %h", t, obs, exp_v);
            end
            per_ack  = 1'b0;
            req_send = 4'b1111 & ~exp_g;
            tick();
            n_cmp++;
            if (obs !== 15'h0) begin
                n_bad++;
                $display("FAIL rr_idle[%0d]: got %h want %h", t, obs, 15'h0);
            end
            req_send = 4'b1111;
        end
    endtask

    task automatic test_mid_reset;
        logic [14:0] exp_v;
        do_reset();
        // Complete one transfer on requester 0 so the pointer moves off 3.
        req_send = 4'b0001;
        tick();
        per_ack = 1'b1;
        tick();
        per_ack  = 1'b0;
        req_send = 4'b0000;
        tick();
        req_dados = 16'h00BC;
        req_send  = 4'b0011;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'hB};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL midrst_pre: got %h want %h", obs, exp_v);
        end
        arb_reset = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL midrst_reset: got %h want %h", obs, 15'h0);
        end
        arb_reset = 1'b1;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'hC};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL midrst_regrant: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_data_stability;
        logic [14:0] exp_v;
        do_reset();
        req_dados = 16'h4327;
        req_send  = 4'b0001;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'h7};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL stab_capture: got %h want %h", obs, exp_v);
        end
        // Data change and request drop during SEND must not disturb the transfer.
        req_dados = 16'h432F;
        req_send  = 4'b0000;
        for (int t = 0; t < 2; t++) begin
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL stab_send[%0d]: got %h want %h", t, obs, exp_v);
            end
        end
        per_ack = 1'b1;
        tick();
        exp_v = {1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'h7};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL stab_release: got %h want %h", obs, exp_v);
        end
        per_ack = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL stab_idle: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp_v;
        do_reset();
        req_dados = 16'h9500;
        req_send  = 4'b0100;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'h5};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want %h", obs, exp_v);
        end
        per_ack = 1'b1;
        tick();
        // Requester 3 raises its flag during RELEASE; not queued.
        per_ack  = 1'b0;
        req_send = 4'b1000;
        tick();
        n_cmp++;
        if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL b2b_gap: got %h want %h", obs, 15'h0);
        end
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'h9};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_second: got %h want %h", obs, exp_v);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [14:0] exp_v;
        do_reset();
        req_dados = 16'h0021;
        req_send  = 4'b0011;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'h1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL tmo_enter: got %h want %h", obs, exp_v);
        end
        for (int t = 1; t < 15; t++) begin
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL tmo_wait[%0d]: got %h want %h", t, obs, exp_v);
            end
        end
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'h0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL tmo_pulse: got %h want %h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'h2};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL tmo_next: got %h want %h", obs, exp_v);
        end
    endtask
`else
    task automatic test_timeout;
        logic [14:0] exp_v;
        do_reset();
        req_dados = 16'h0021;
        req_send  = 4'b0011;
        tick();
        for (int t = 0; t < 20; t++) begin
            tick();
        end
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'h1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL notmo_wait: got %h want %h", obs, exp_v);
        end
    endtask
`endif

    initial begin
        arb_reset = 1'b0;
        req_send  = 4'b0000;
        req_dados = 16'h0000;
        per_ack   = 1'b0;
        test_reset();
        test_single();
        test_idle_ack();
        test_round_robin();
        test_mid_reset();
        test_data_stability();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbitro.md
BUS_ARBITRO -- requirements
Module: bus_arbitro

Interface
REQ-001 Parameter N_REQ, default 4: number of CPU requesters, range 2..8.
REQ-002 Parameter DATA_W, default 4: data bus width.
REQ-003 Parameter TIMEOUT_CYC, default 15: ack wait limit in cycles, used only with ARB_TIMEOUT_EN.
REQ-004 arb_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 arb_reset  in  1  synchronous, active-low reset (0 = reset), sampled on the arb_clock rising edge.
REQ-006 req_send  in  N_REQ  per-requester "data on bus" flag; bit i belongs to requester i.
REQ-007 req_dados  in  N_REQ*DATA_W  requester data; slice i is requester i.
REQ-008 req_ack  out  N_REQ  per-requester receipt ack; at most one bit high.
REQ-009 per_send  out  1  send flag to the peripheral.
REQ-010 per_dados  out  DATA_W  data to the peripheral.
REQ-011 per_ack  in  1  peripheral receipt ack.
REQ-012 arb_grant  out  N_REQ  one-hot owner of the bus; all-zero when idle.
REQ-013 arb_busy  out  1  high whenever the state is not IDLE.
REQ-014 arb_erro  out  1  one-cycle timeout pulse; tied to 0 without ARB_TIMEOUT_EN.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND, RELEASE.
REQ-016 IDLE: when any req_send bit is 1, select a winner round-robin, starting at (last_winner+1) mod N_REQ.
- Same edge: latch the winner into arb_grant, capture its req_dados slice into the per_dados register, go to SEND.
REQ-017 Latency: req_send sampled high at edge k gives per_send=1 after edge k (one-cycle request-to-send latency).
REQ-018 SEND: per_send=1, per_dados held constant.
- Requester data changes during SEND are ignored.
- A requester dropping req_send during SEND does not abort the transfer.
REQ-019 SEND with per_ack=1 at an edge: go to RELEASE, per_send=0, req_ack[winner]=1.
REQ-020 RELEASE: req_ack[winner] stays 1 until per_ack=0 and req_send[winner]=0 are both sampled at the same edge.
- On that edge: go to IDLE, drop req_ack, clear arb_grant, set last_winner=winner.
REQ-021 Back-to-back traffic: a new request may win on the first IDLE edge.
- Minimum cost is one idle cycle between transfers.
REQ-022 Fairness: with all N_REQ requesters continuously requesting, each is granted exactly once per N_REQ transfers.
REQ-023 Requests arriving while not IDLE are not queued; they are re-evaluated on the next IDLE edge.
REQ-024 per_ack=1 while in IDLE is ignored; no output changes.
REQ-025 per_dados SHALL be 0 in IDLE.
REQ-026 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-027 arb_reset=0 at an edge forces state IDLE, regardless of current state, including mid-transfer.
REQ-028 Reset values: per_send=0, per_dados=0, req_ack=0, arb_grant=0, arb_busy=0, arb_erro=0.
REQ-029 Reset sets last_winner=N_REQ-1, so requester 0 has first priority after reset.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN defined:
- A counter runs in SEND.
- If per_ack is not seen within TIMEOUT_CYC cycles: pulse arb_erro for one cycle, drop per_send, go to IDLE without asserting req_ack, set last_winner=winner.
- The counter clears on SEND entry.
REQ-031 Macro ARB_TIMEOUT_EN undefined: SEND waits indefinitely, no counter logic exists, and arb_erro is constant 0.

Structure
REQ-032 Shared package arb_pkg: state enum (IDLE, SEND, RELEASE) and default N_REQ, DATA_W, TIMEOUT_CYC constants.
REQ-033 Sub-module arb_rr_pick: purely combinational round-robin picker.
- Inputs: request vector, last_winner.
- Outputs: one-hot winner, valid flag.

Verification
REQ-034 Reset: hold arb_reset=0 for 2 cycles, then release with req_send=0 -> all outputs 0, arb_busy=0.
REQ-035 Single transfer: req_send=0001, slice 0 = 4'hA; peripheral acks 2 cycles after per_send rises.
- Required: per_send=1 one cycle after request, per_dados=4'hA, arb_grant=0001.
- Required: req_ack[0]=1 after per_ack, cleared after req_send[0] and per_ack both drop.
REQ-036 Round-robin: req_send=1111 held through 8 handshakes -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Mid-transfer reset: assert arb_reset=0 in SEND -> next edge per_send=0, arb_grant=0, state IDLE; next grant goes to requester 0.
REQ-038 Data stability: change the winner's req_dados during SEND -> per_dados unchanged until IDLE.
REQ-039 ARB_TIMEOUT_EN, TIMEOUT_CYC=15: per_ack held 0 -> after 15 SEND cycles, arb_erro pulses once, req_ack stays 0, next pending requester wins.
